alu_iter: RTL

Multi-cycle execute unit that consumes the 3-bit ALUControl code produced by the ALU decoder, plus the `funct7b5` modifier, and computes the RV32I integer result. Sits between decode/operand-select and writeback in the multi-cycle core variant. Uses a valid/ready handshake on both sides and an iterative 1-bit-per-cycle shifter, so shifts cost extra cycles while all other operations complete in one.

---
 rtl/alu_iter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// alu_iter -- multi-cycle RV32I execute unit with valid/ready handshakes.
//
// Accepts an ALUControl code plus the alt modifier (SUB / arithmetic shift)
// and two operands, and produces a registered result and Zero flag. Every
// operation except a non-zero shift completes in one cycle. In the default
// build, shifts use an iterative 1-bit-per-cycle shifter. Defining the macro
// ALU_ITER_FAST_SHIFT_EN replaces it with a single-cycle barrel shifter.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset; aborts any operation in flight
//   in_valid    operation request
//   in_ready    high in IDLE only; accept = in_valid & in_ready
//   ALUControl  3-bit operation code (ALU_* encodings below)
//   alt         SUB for ALU_ADD, arithmetic shift for ALU_SR; ignored otherwise
//   SrcA, SrcB  operands; shift amount is SrcB[$clog2(WIDTH)-1:0]
//   out_valid   high in DONE; holds until out_ready
//   out_ready   consumer accepts the result
//   ALUResult   registered result
//   Zero        registered flag, ALUResult == 0
module alu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic             alt,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    localparam int unsigned SHW = $clog2(WIDTH);

    // ALU_* encodings shared with the decoder (funct3 ordering)
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SL   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SR   = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

`ifdef ALU_ITER_FAST_SHIFT_EN
    typedef enum logic {
        S_IDLE,
        S_DONE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] op_res;

`ifndef ALU_ITER_FAST_SHIFT_EN
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             shl_q, shl_d;     // latched direction: 1 = left
    logic             arith_q, arith_d; // latched alt for right shifts
    logic [WIDTH-1:0] sh_next;
    logic             is_shift;
`endif

    assign shamt     = SrcB[SHW-1:0];
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;

    // Single-cycle result for the accept edge. In the iterative build a
    // shift only takes this path when shamt == 0, so it returns SrcA.
    always_comb begin
        op_res = '0;
        case (ALUControl)
            ALU_ADD:  op_res = alt ? (SrcA - SrcB) : (SrcA + SrcB);
`ifdef ALU_ITER_FAST_SHIFT_EN
            ALU_SL:   op_res = SrcA << shamt;
            ALU_SR: begin
                if (alt) op_res = $signed(SrcA) >>> shamt;
                else     op_res = SrcA >> shamt;
            end
`else
            ALU_SL:   op_res = SrcA;
            ALU_SR:   op_res = SrcA;
`endif
            ALU_SLT:  op_res = WIDTH'($signed(SrcA) < $signed(SrcB));
            ALU_SLTU: op_res = WIDTH'(SrcA < SrcB);
            ALU_XOR:  op_res = SrcA ^ SrcB;
            ALU_OR:   op_res = SrcA | SrcB;
            ALU_AND:  op_res = SrcA & SrcB;
            default:  op_res = '0;
        endcase
    end

`ifndef ALU_ITER_FAST_SHIFT_EN
    assign is_shift = (ALUControl == ALU_SL) || (ALUControl == ALU_SR);
    assign sh_next  = shl_q ? {sreg_q[WIDTH-2:0], 1'b0}
                            : {arith_q & sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_ITER_FAST_SHIFT_EN
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        shl_d    = shl_q;
        arith_d  = arith_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifndef ALU_ITER_FAST_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        sreg_d  = SrcA;
                        cnt_d   = shamt;
                        shl_d   = (ALUControl == ALU_SL);
                        arith_d = alt;
                        state_d = S_SHIFT;
                    end else
`endif
                    begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
`ifndef ALU_ITER_FAST_SHIFT_EN
            S_SHIFT: begin
                sreg_d = sh_next;
                cnt_d  = cnt_q - SHW'(1);
                // Last step: register the value the shifter produces this cycle
                if (cnt_q == SHW'(1)) begin
                    result_d = sh_next;
                    zero_d   = (sh_next == '0);
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifndef ALU_ITER_FAST_SHIFT_EN
            sreg_q   <= '0;
            cnt_q    <= '0;
            shl_q    <= 1'b0;
            arith_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_ITER_FAST_SHIFT_EN
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            shl_q    <= shl_d;
            arith_q  <= arith_d;
`endif
        end
    end

endmodule
